// File: rtl/record_controller.sv
// Take controller: discards settling PDM words, then streams captured words to memory via a one-deep holding register.
// Optional feature: define RECORD_CONTROLLER_OVERRUN_COUNT_EN to add a saturating per-take overrun_count_o output.
module record_controller #(
   parameter int WORD_LENGTH   = 16,
   parameter int ADDR_WIDTH    = 14,
   parameter int RECORD_WORDS  = 16384,
   parameter int DISCARD_WORDS = 4
) (
   input  logic                   clock_i,
   input  logic                   reset_n_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [ADDR_WIDTH:0]    word_count_o,
   output logic                   overrun_o,
`ifdef RECORD_CONTROLLER_OVERRUN_COUNT_EN
   output logic [15:0]            overrun_count_o,
`endif
   output logic                   des_enable_o,
   input  logic                   des_done_i,
   input  logic [WORD_LENGTH-1:0] des_data_i,
   output logic                   mem_valid_o,
   input  logic                   mem_ready_i,
   output logic [ADDR_WIDTH-1:0]  mem_addr_o,
   output logic [WORD_LENGTH-1:0] mem_data_o
);

   localparam int CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_RECORD,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [7:0]             discard_cnt;
   logic [CNT_W-1:0]       capture_idx;
   logic                   hold_valid;
   logic [ADDR_WIDTH-1:0]  hold_addr;
   logic [WORD_LENGTH-1:0] hold_data;
   logic [CNT_W-1:0]       word_count;
   logic                   overrun;
   logic                   des_enable;
`ifdef RECORD_CONTROLLER_OVERRUN_COUNT_EN
   logic [15:0]            overrun_count;
`endif

   logic start_take;
   logic handshake;
   logic capture;
   logic drop;
   logic last_capture;
   logic discard_last;

   // A word may enter the holding register whenever it is empty or being emptied this same cycle.
   assign start_take   = start_i && ((state == S_IDLE) || (state == S_DONE));
   assign handshake    = hold_valid && mem_ready_i;
   assign capture      = (state == S_RECORD) && des_done_i && (!hold_valid || mem_ready_i);
   assign drop         = (state == S_RECORD) && des_done_i && hold_valid && !mem_ready_i;
   assign last_capture = capture && (capture_idx == CNT_W'(RECORD_WORDS - 1));
   assign discard_last = (state == S_SETTLE) && des_done_i && (discard_cnt == 8'(DISCARD_WORDS - 1));

   always_comb begin
      // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
      next_state = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start_i) next_state = (DISCARD_WORDS == 0) ? S_RECORD : S_SETTLE;
         end
         S_SETTLE: begin
            if (stop_i)            next_state = S_DONE;
            else if (discard_last) next_state = S_RECORD;
         end
         S_RECORD: begin
            if (stop_i || last_capture) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (!hold_valid || handshake) next_state = S_DONE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state       <= S_IDLE;
         des_enable  <= 1'b0;
         discard_cnt <= '0;
         capture_idx <= '0;
         hold_valid  <= 1'b0;
         hold_addr   <= '0;
         hold_data   <= '0;
         word_count  <= '0;
         overrun     <= 1'b0;
`ifdef RECORD_CONTROLLER_OVERRUN_COUNT_EN
         overrun_count <= '0;
`endif
      end else begin
         state      <= next_state;
         des_enable <= (next_state == S_SETTLE) || (next_state == S_RECORD);

         if (start_take)
            discard_cnt <= '0;
         else if ((state == S_SETTLE) && des_done_i)
            discard_cnt <= discard_cnt + 8'd1;

         // capture_idx stops at RECORD_WORDS because RECORD leaves on the last capture.
         if (start_take)
            capture_idx <= '0;
         else if (capture)
            capture_idx <= capture_idx + CNT_W'(1);

         if (capture) begin
            hold_valid <= 1'b1;
            hold_addr  <= capture_idx[ADDR_WIDTH-1:0];
            hold_data  <= des_data_i;
         end else if (handshake) begin
            hold_valid <= 1'b0;
         end

         if (start_take)
            word_count <= '0;
         else if (handshake)
            word_count <= word_count + CNT_W'(1);

         if (start_take)
            overrun <= 1'b0;
         else if (drop)
            overrun <= 1'b1;

`ifdef RECORD_CONTROLLER_OVERRUN_COUNT_EN
         if (start_take)
            overrun_count <= '0;
         else if (drop && (overrun_count != 16'hFFFF))
            overrun_count <= overrun_count + 16'd1;
`endif
      end
   end

   assign busy_o       = (state == S_SETTLE) || (state == S_RECORD) || (state == S_DRAIN);
   assign done_o       = (state == S_DONE);
   assign word_count_o = word_count;
   assign overrun_o    = overrun;
   assign des_enable_o = des_enable;
   assign mem_valid_o  = hold_valid;
   assign mem_addr_o   = hold_addr;
   assign mem_data_o   = hold_data;
`ifdef RECORD_CONTROLLER_OVERRUN_COUNT_EN
   assign overrun_count_o = overrun_count;
`endif

endmodule
